// File: rtl/hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Forward-select codes and the mult/div tracker state encoding.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/hazard_ctrl_mc_md_busy_tracker.sv
// Multi-cycle mult/div busy tracker: HI/LO interlock source for the hazard unit.
//   state   | meaning
//   MD_IDLE | no mult/div in flight, accepts a qualified start
//   MD_BUSY | op executing, cnt counts down to the last busy cycle
import hazard_pkg::*;

module md_busy_tracker #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic MdBusy
);

  localparam int unsigned CW = $clog2(MD_LATENCY);
  localparam logic [CW-1:0] LOAD = CW'(MD_LATENCY - 1);
  localparam logic [CW-1:0] LAST = CW'(1);

  md_state_t     state;
  logic [CW-1:0] cnt;

  // Runs free of stalls; a start while busy is blocked upstream and ignored here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      MdBusy <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            state  <= MD_BUSY;
            cnt    <= LOAD;
            MdBusy <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (cnt == LAST) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            MdBusy <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= MD_IDLE;
          cnt    <= '0;
          MdBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the five-stage MIPS core: forwarding, stalls, flushes, mult/div interlock.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
import hazard_pkg::*;

module hazard_ctrl_mc #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              MemtoRegM,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              PCSrcD,
  input  logic              MdStartE,
  input  logic              MdStartD,
  input  logic              MdReadD,
  input  logic              DmemReadyM,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  logic memwait, lwstall, branchstall, mdstall, hz, md_start;

  always_comb begin
    ForwardAE = FWD_RF;
    if (RsE != '0 && RsE == WriteRegM && RegWriteM)      ForwardAE = FWD_MEM;
    else if (RsE != '0 && RsE == WriteRegW && RegWriteW) ForwardAE = FWD_WB;
    ForwardBE = FWD_RF;
    if (RtE != '0 && RtE == WriteRegM && RegWriteM)      ForwardBE = FWD_MEM;
    else if (RtE != '0 && RtE == WriteRegW && RegWriteW) ForwardBE = FWD_WB;
  end

  assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
  assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

  assign lwstall = MemtoRegE && (RtE != '0) && ((RsD == RtE) || (RtD == RtE));
  assign branchstall = BranchD &&
      ((RegWriteE && WriteRegE != '0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
       (MemtoRegM && WriteRegM != '0 && (WriteRegM == RsD || WriteRegM == RtD)));
  assign mdstall = (MdBusy || MdStartE) && (MdStartD || MdReadD);
  assign hz      = lwstall || branchstall || mdstall;
  assign memwait = ~DmemReadyM;

  // Memory wait freezes the whole pipe and outranks any D-stage hazard.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (memwait) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (hz) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      FlushD = JumpD || PCSrcD;
    end
  end

  assign md_start = MdStartE && !StallE && !FlushE;

  md_busy_tracker #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy_tracker (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .MdBusy (MdBusy)
  );

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Saturating so long runs never alias back to small counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (StallF && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if ((FlushD || FlushE || FlushW) && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed self-checking bench for hazard_ctrl_mc with an expected-value scoreboard.
module tb_hazard_ctrl_mc;

  localparam int AW = 5;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic BranchD, JumpD, PCSrcD, MdStartE, MdStartD, MdReadD, DmemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAD, ForwardBD, MdBusy;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] StallCnt, FlushCnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [13:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  hazard_ctrl_mc #(.REG_AW(AW), .MD_LATENCY(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .JumpD(JumpD), .PCSrcD(PCSrcD),
    .MdStartE(MdStartE), .MdStartD(MdStartD), .MdReadD(MdReadD),
    .DmemReadyM(DmemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MdBusy(MdBusy), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  // Expected output vector: {sf,sd,se,sm,fd,fe,fw,ad,bd,ae,be,busy}
  function automatic logic [13:0] mk(input logic sf, sd, se, sm, fd, fe, fw, ad, bd,
                                     input logic [1:0] ae, be, input logic busy);
    return {sf, sd, se, sm, fd, fe, fw, ad, bd, ae, be, busy};
  endfunction

  task automatic clr();
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
    BranchD = 0; JumpD = 0; PCSrcD = 0; MdStartE = 0; MdStartD = 0; MdReadD = 0;
    DmemReadyM = 1;
  endtask

  task automatic push(input string t, input logic [13:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    logic [13:0] obs, exp;
    string t;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      t   = tag_q.pop_front();
      obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAD, ForwardBD, ForwardAE, ForwardBE, MdBusy};
      n_assert++;
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", t, obs, exp);
      end
    end
  endtask

  task automatic check_cnt(input string t, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", t, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic samp();
    @(negedge clk);
    check_out();
  endtask

  localparam logic [13:0] Z = 14'b0;

  initial begin
    clr();
    rst_n = 0;
    push("reset_outputs", Z);
    samp();
    check_cnt("reset_stallcnt", StallCnt, 16'd0);
    check_cnt("reset_flushcnt", FlushCnt, 16'd0);
    #2 rst_n = 1;
    cyc();

    // Forwarding
    clr(); RsE = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1;
    push("fwd_ae_mem_priority", mk(0,0,0,0,0,0,0,0,0,2'b10,2'b00,0)); samp(); cyc();
    RsE = 0;
    push("fwd_ae_r0", Z); samp(); cyc();
    clr(); RsE = 3; WriteRegM = 9; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1; RtE = 9; RsD = 9; RtD = 3;
    push("fwd_mix", mk(0,0,0,0,0,0,0,1,0,2'b01,2'b10,0)); samp(); cyc();
    clr(); RsE = 3; WriteRegM = 3; RegWriteM = 0; WriteRegW = 3; RegWriteW = 1; RtD = 3;
    push("fwd_ae_wb_gated", mk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,0)); samp(); cyc();
    clr(); RtD = 7; WriteRegM = 7; RegWriteM = 1; RtE = 7;
    push("fwd_bd_be", mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,0)); samp(); cyc();

    // Load-use
    clr(); MemtoRegE = 1; RtE = 5; RsD = 5;
    push("lwstall_rs", mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,0)); samp(); cyc();
    clr(); MemtoRegE = 1; RtE = 0; RsD = 0;
    push("lwstall_r0", Z); samp(); cyc();
    clr(); MemtoRegE = 1; RtE = 5; RtD = 5; RsD = 2;
    push("lwstall_rt", mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,0)); samp(); cyc();

    // Branch
    clr(); BranchD = 1; RegWriteE = 1; WriteRegE = 6; RsD = 6;
    push("brstall_e", mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,0)); samp(); cyc();
    clr(); BranchD = 1; RegWriteE = 1; WriteRegE = 0;
    push("brstall_r0", Z); samp(); cyc();
    clr(); BranchD = 1; MemtoRegM = 1; WriteRegM = 8; RtD = 8;
    push("brstall_m", mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,0)); samp(); cyc();

    // Jump / redirect
    clr(); JumpD = 1;
    push("jump_flush", mk(0,0,0,0,1,0,0,0,0,2'b00,2'b00,0)); samp(); cyc();
    clr(); PCSrcD = 1;
    push("pcsrc_flush", mk(0,0,0,0,1,0,0,0,0,2'b00,2'b00,0)); samp(); cyc();
    clr(); JumpD = 1; MemtoRegE = 1; RtE = 5; RsD = 5;
    push("jump_lwstall", mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,0)); samp(); cyc();

    // Memory wait overriding load-use, two cycles
    clr(); DmemReadyM = 0; MemtoRegE = 1; RtE = 5; RsD = 5; JumpD = 1;
    push("memwait_c1", mk(1,1,1,1,0,0,1,0,0,2'b00,2'b00,0)); samp(); cyc();
    push("memwait_c2", mk(1,1,1,1,0,0,1,0,0,2'b00,2'b00,0)); samp(); cyc();
    DmemReadyM = 1;
    push("memwait_release", mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,0)); samp(); cyc();

    // Mult/div issue then dependent read
    clr(); MdStartE = 1;
    push("md_issue", Z); samp(); cyc();
    MdStartE = 0; MdReadD = 1;
    push("md_busy1", mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,1)); samp(); cyc();
    MdReadD = 0; MdStartD = 1;
    push("md_busy2", mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,1)); samp(); cyc();
    MdStartD = 0; MdReadD = 1;
    push("md_busy3", mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,1)); samp(); cyc();
    push("md_done", Z); samp(); cyc();

    // Issue suppressed by memwait and by a flushed E stage
    clr(); DmemReadyM = 0; MdStartE = 1;
    push("md_memwait_hold", mk(1,1,1,1,0,0,1,0,0,2'b00,2'b00,0)); samp(); cyc();
    clr();
    push("md_no_issue_memwait", Z); samp(); cyc();
    clr(); MdStartE = 1; MemtoRegE = 1; RtE = 5; RsD = 5;
    push("md_flushE_block", mk(1,1,0,0,0,1,0,0,0,2'b00,2'b00,0)); samp(); cyc();
    clr();
    push("md_no_issue_flush", Z); samp(); cyc();

    // Async reset mid-busy
    clr(); MdStartE = 1; cyc();
    MdStartE = 0;
    push("md_busy_pre_rst", mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,1)); samp();
    #2 rst_n = 0;
    #1;
    push("md_async_rst", Z); check_out();
    #1 rst_n = 1;
    cyc();
    push("md_after_rst", Z); samp(); cyc();

    // Performance counters
    clr(); JumpD = 1;
    repeat (5) cyc();
    clr();
    @(negedge clk);
`ifdef HAZ_PERF_CNT_EN
    check_cnt("flushcnt_jump", FlushCnt, 16'd5);
    check_cnt("stallcnt_jump", StallCnt, 16'd0);
    MemtoRegE = 1; RtE = 5; RsD = 5;
    repeat ((1 << CW) + 3) cyc();
    clr();
    @(negedge clk);
    check_cnt("stallcnt_sat", StallCnt, 16'hFFFF);
    check_cnt("flushcnt_sat", FlushCnt, 16'hFFFF);
`else
    check_cnt("flushcnt_off", FlushCnt, 16'd0);
    MemtoRegE = 1; RtE = 5; RsD = 5;
    repeat (10) cyc();
    clr();
    @(negedge clk);
    check_cnt("stallcnt_off", StallCnt, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
